// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter.
// Requester 0 (core) and requester 1 (loader) share one memory port.
// One transaction is in flight at a time: IDLE -> ACCESS (MEM_LAT cycles) -> COMPLETE.
// Ties are resolved round-robin, and requester 0 wins the first tie after reset.
module mem_bus_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       READ,
    output logic       WRITE,
    output logic [4:0] MEM_ADDR,
    output logic [7:0] MEM_DATA_OUT,
    output logic       mc_en,
    input  logic [7:0] mem_data_in,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;          // requester owning the transaction in flight
    logic       rr_q, rr_d;            // 1 = requester 1 wins the next tie
    logic       we_q, we_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       read_q, read_d;
    logic       write_q, write_d;
    logic [4:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_out_q, mem_data_out_d;
    logic       mc_en_q, mc_en_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;

    logic       gnt0_w, gnt1_w;
    logic       win_we;
    logic [4:0] win_addr;
    logic [7:0] win_wdata;

    // Grant decision. The grant is combinational so it appears in the IDLE cycle
    // that sees the request. It is gated by reset so all outputs stay low while reset is held.
    always_comb begin
        gnt0_w = 1'b0;
        gnt1_w = 1'b0;
        if (reset && state_q == IDLE) begin
            if (req0 && req1) begin
                gnt0_w = ~rr_q;
                gnt1_w = rr_q;
            end else begin
                gnt0_w = req0;
                gnt1_w = req1;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        win_we    = gnt1_w ? we1    : we0;
        win_addr  = gnt1_w ? addr1  : addr0;
        win_wdata = gnt1_w ? wdata1 : wdata0;
    end

    // Next-state and next-output logic. The bus outputs are registered: each is
    // computed for the state being entered on the coming edge.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        rr_d           = rr_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        read_d         = read_q;
        write_d        = write_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        mc_en_d        = mc_en_q;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                read_d         = 1'b0;
                write_d        = 1'b0;
                mem_addr_d     = '0;
                mem_data_out_d = '0;
                mc_en_d        = 1'b0;
                busy_d         = 1'b0;
                if (gnt0_w || gnt1_w) begin
                    sel_d          = gnt1_w;
                    we_d           = win_we;
                    addr_d         = win_addr;
                    wdata_d        = win_wdata;
                    cnt_d          = 4'(MEM_LAT);
                    state_d        = ACCESS;
                    read_d         = ~win_we;
                    write_d        = win_we;
                    mem_addr_d     = win_addr;
                    mem_data_out_d = win_we ? win_wdata : '0;
                    mc_en_d        = win_we;
                    busy_d         = 1'b1;
                end
            end

            ACCESS: begin
                if (cnt_q <= 4'd1) begin
                    // Last strobe cycle: capture read data now so it is valid with the ack.
                    state_d        = COMPLETE;
                    cnt_d          = '0;
                    read_d         = 1'b0;
                    write_d        = 1'b0;
                    mem_addr_d     = '0;
                    mem_data_out_d = '0;
                    mc_en_d        = 1'b0;
                    ack0_d         = ~sel_q;
                    ack1_d         = sel_q;
                    if (!we_q) begin
                        rdata_d = mem_data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            COMPLETE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rr_d    = ~sel_q;
            end

            default: begin
                state_d        = IDLE;
                cnt_d          = '0;
                read_d         = 1'b0;
                write_d        = 1'b0;
                mem_addr_d     = '0;
                mem_data_out_d = '0;
                mc_en_d        = 1'b0;
                busy_d         = 1'b0;
            end
        endcase
    end

    // State and registered outputs. Asynchronous active-low reset aborts any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sel_q          <= 1'b0;
            rr_q           <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mc_en_q        <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            rr_q           <= rr_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            read_q         <= read_d;
            write_q        <= write_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            mc_en_q        <= mc_en_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            busy_q         <= busy_d;
        end
    end

    assign gnt0         = gnt0_w;
    assign gnt1         = gnt1_w;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata        = rdata_q;
    assign READ         = read_q;
    assign WRITE        = write_q;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_DATA_OUT = mem_data_out_q;
    assign mc_en        = mc_en_q;
    assign busy         = busy_q;

endmodule
